// File: rtl/irrigation_pkg.sv
// Shared types and helpers for the multi-zone irrigation controller.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_IRR   = 3'd2,
    ST_CLEAN = 3'd3
  } state_e;

  localparam logic MODE_SPRK = 1'b0;
  localparam logic MODE_DRIP = 1'b1;

  // First set bit of pend at or above rr, wrapping within n zones.
  function automatic logic [2:0] rr_next_zone(
    input logic [7:0] pend,
    input logic [2:0] rr,
    input int         n
  );
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = rr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(rr) + i) % n;
      if (!found && i < n && pend[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/multi_zone_irrigation_ctrl.sv
// Tank fill, round-robin zone irrigation and pesticide clean-out sequencer.
module multi_zone_irrigation_ctrl
  import irrigation_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int TIMER_W   = 8,
  parameter int TICK_DIV  = 50_000_000,
  parameter int FILL_T    = 10,
  parameter int SPRK_T    = 6,
  parameter int DRIP_T    = 12,
  parameter int CLEAN_T   = 4
) (
  input  logic                 clk_50mhz,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [NUM_ZONES-1:0] soil_dry_i,
  input  logic                 temp_hot_i,
  input  logic                 air_dry_i,
  input  logic                 pesticide_i,
  output logic [2:0]           state_o,
  output logic                 fill_valve_o,
  output logic [NUM_ZONES-1:0] zone_valve_o,
  output logic                 mode_o,
  output logic [TIMER_W-1:0]   remaining_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 alert_np_o
);

  localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam logic [NUM_ZONES-1:0] ONE = NUM_ZONES'(1);

  state_e               r_state, n_state;
  logic [NUM_ZONES-1:0] r_pend, n_pend, w_pend_cl;
  logic [ZW-1:0]        r_rr, n_rr, w_next_rr;
  logic [ZW-1:0]        r_zone, n_zone;
  logic                 r_pest, n_pest;
  logic                 r_mode, n_mode;
  logic [TIMER_W-1:0]   r_rem, n_rem;
  logic                 r_alert, n_alert;
  logic                 r_done, n_done;
  logic                 r_fill, r_busy;
  logic [NUM_ZONES-1:0] r_zv, w_zv;
  logic                 w_tick, w_end, w_load, w_clr;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .i_clk  (clk_50mhz),
    .i_rst_n(reset_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  assign w_end = w_tick && (r_rem == TIMER_W'(1));
  assign w_clr = w_load || (r_state == ST_IDLE);

  always_comb begin
    n_state   = r_state;
    n_pend    = r_pend;
    n_rr      = r_rr;
    n_zone    = r_zone;
    n_pest    = r_pest;
    n_mode    = r_mode;
    n_rem     = r_rem;
    n_alert   = r_alert;
    n_done    = 1'b0;
    w_load    = 1'b0;
    w_pend_cl = r_pend;
    w_next_rr = r_rr;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          n_pend  = soil_dry_i;
          n_pest  = pesticide_i;
          n_alert = ~pesticide_i;
          if (soil_dry_i == '0) begin
            n_done = 1'b1;
          end else begin
            n_state = ST_FILL;
            n_rem   = TIMER_W'(FILL_T);
            w_load  = 1'b1;
          end
        end
      end
      ST_FILL, ST_IRR: begin
        if (stop_i) begin
          n_pend = '0;
          if (r_pest) begin
            n_state = ST_CLEAN;
            n_rem   = TIMER_W'(CLEAN_T);
            w_load  = 1'b1;
          end else begin
            n_state = ST_IDLE;
            n_done  = 1'b1;
          end
        end else if (w_end) begin
          if (r_state == ST_IRR) begin
            w_pend_cl = r_pend & ~(ONE << r_zone);
            w_next_rr = (r_zone == ZW'(NUM_ZONES - 1))
                      ? '0 : r_zone + 1'b1;
          end
          n_pend = w_pend_cl;
          n_rr   = w_next_rr;
          if (w_pend_cl != '0) begin
            n_state = ST_IRR;
            n_zone  = ZW'(rr_next_zone(8'(w_pend_cl),
                                       3'(w_next_rr),
                                       NUM_ZONES));
            n_mode  = (temp_hot_i | air_dry_i)
                    ? MODE_DRIP : MODE_SPRK;
            n_rem   = (n_mode == MODE_DRIP)
                    ? TIMER_W'(DRIP_T) : TIMER_W'(SPRK_T);
            w_load  = 1'b1;
          end else if (r_pest) begin
            n_state = ST_CLEAN;
            n_rem   = TIMER_W'(CLEAN_T);
            w_load  = 1'b1;
          end else begin
            n_state = ST_IDLE;
            n_done  = 1'b1;
          end
        end else if (w_tick) begin
          n_rem = r_rem - TIMER_W'(1);
        end
      end
      ST_CLEAN: begin
        if (w_end) begin
          n_state = ST_IDLE;
          n_done  = 1'b1;
        end else if (w_tick) begin
          n_rem = r_rem - TIMER_W'(1);
        end
      end
      default: n_state = ST_IDLE;
    endcase
    // Outputs only carry meaning inside their own state.
    if (n_state == ST_IDLE) n_rem = '0;
    if (n_state != ST_IRR) n_mode = MODE_SPRK;
    unique case (n_state)
      ST_IRR:   w_zv = ONE << n_zone;
      ST_CLEAN: w_zv = '1;
      default:  w_zv = '0;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_rr    <= '0;
      r_zone  <= '0;
      r_pest  <= 1'b0;
      r_mode  <= 1'b0;
      r_rem   <= '0;
      r_alert <= 1'b0;
      r_done  <= 1'b0;
      r_fill  <= 1'b0;
      r_busy  <= 1'b0;
      r_zv    <= '0;
    end else begin
      r_state <= n_state;
      r_pend  <= n_pend;
      r_rr    <= n_rr;
      r_zone  <= n_zone;
      r_pest  <= n_pest;
      r_mode  <= n_mode;
      r_rem   <= n_rem;
      r_alert <= n_alert;
      r_done  <= n_done;
      r_fill  <= (n_state == ST_FILL);
      r_busy  <= (n_state != ST_IDLE);
      r_zv    <= w_zv;
    end
  end

  assign state_o      = r_state;
  assign fill_valve_o = r_fill;
  assign zone_valve_o = r_zv;
  assign mode_o       = r_mode;
  assign remaining_o  = r_rem;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign alert_np_o   = r_alert;

endmodule

// File: tb/tb_multi_zone_irrigation_ctrl.sv
// Bench for multi_zone_irrigation_ctrl: vector table, corner sequences, random vs model.
module tb_multi_zone_irrigation_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int FT = 3;
  localparam int SP = 2;
  localparam int DR = 5;
  localparam int CT = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] soil = 4'h0;
  logic       temp = 1'b0;
  logic       air = 1'b0;
  logic       pest = 1'b0;
  logic [2:0] state_o;
  logic       fill_valve_o;
  logic [3:0] zone_valve_o;
  logic       mode_o;
  logic [7:0] remaining_o;
  logic       busy_o;
  logic       done_o;
  logic       alert_np_o;

  int checks = 0;
  int failures = 0;

  multi_zone_irrigation_ctrl #(
    .NUM_ZONES(N), .TIMER_W(8), .TICK_DIV(TD),
    .FILL_T(FT), .SPRK_T(SP), .DRIP_T(DR), .CLEAN_T(CT)
  ) dut (
    .clk_50mhz   (clk),
    .reset_n     (reset_n),
    .start_i     (start),
    .stop_i      (stop),
    .soil_dry_i  (soil),
    .temp_hot_i  (temp),
    .air_dry_i   (air),
    .pesticide_i (pest),
    .state_o     (state_o),
    .fill_valve_o(fill_valve_o),
    .zone_valve_o(zone_valve_o),
    .mode_o      (mode_o),
    .remaining_o (remaining_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .alert_np_o  (alert_np_o)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as raw clock cycles left in the phase.
  int       m_st, m_left, m_zone, m_rr;
  bit [3:0] m_pend;
  bit       m_pest, m_mode, m_alert, m_done;

  function automatic int pick(bit [3:0] p, int rr);
    for (int k = 0; k < N; k++)
      if (p[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  task automatic finish_run();
    if (m_pest) begin
      m_st = 3; m_left = CT * TD;
    end else begin
      m_st = 0; m_done = 1'b1;
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_st = 0; m_left = 0; m_zone = 0; m_rr = 0;
      m_pend = 0; m_pest = 0; m_mode = 0;
      m_alert = 0; m_done = 0;
      return;
    end
    m_done = 1'b0;
    case (m_st)
      0: if (start) begin
        m_pend = soil; m_pest = pest; m_alert = !pest;
        if (soil == 0) m_done = 1'b1;
        else begin m_st = 1; m_left = FT * TD; end
      end
      1, 2: if (stop) begin
        m_pend = 0;
        finish_run();
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_st == 2) begin
            m_pend[m_zone] = 1'b0;
            m_rr = (m_zone + 1) % N;
          end
          if (m_pend != 0) begin
            m_zone = pick(m_pend, m_rr);
            m_mode = temp | air;
            m_st = 2;
            m_left = (m_mode ? DR : SP) * TD;
          end else finish_run();
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_st = 0; m_done = 1'b1; end
      end
    endcase
  endtask

  function automatic logic [19:0] model_out();
    logic [3:0] zv;
    logic [7:0] rem;
    zv = (m_st == 2) ? 4'(1 << m_zone) : (m_st == 3) ? 4'hF : 4'h0;
    rem = (m_st == 0) ? 8'd0 : 8'((m_left + TD - 1) / TD);
    return {3'(m_st), m_st == 1, zv, (m_st == 2) && m_mode,
            rem, m_st != 0, m_done, m_alert};
  endfunction

  function automatic logic [19:0] dut_out();
    return {state_o, fill_valve_o, zone_valve_o, mode_o,
            remaining_o, busy_o, done_o, alert_np_o};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic wait_cyc(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  typedef struct {
    bit       start;
    bit       stop;
    bit [3:0] soil;
    bit       temp;
    bit       air;
    bit       pest;
    int       n;
    bit [2:0] st;
    bit [3:0] zv;
    bit [7:0] rem;
    bit       mode;
    bit       done;
    bit       alert;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // sprinkler run over zones 0 and 2 with clean-out
    tbl.push_back('{1, 0, 4'b0101, 0, 0, 1, 1,  1, 4'h0, 3, 0, 0, 0});
    tbl.push_back('{0, 0, 4'b0101, 0, 0, 1, 4,  1, 4'h0, 2, 0, 0, 0});
    tbl.push_back('{0, 0, 4'b0101, 0, 0, 1, 8,  2, 4'h1, 2, 0, 0, 0});
    tbl.push_back('{0, 0, 4'b0101, 0, 0, 1, 7,  2, 4'h1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 4'b0101, 0, 0, 1, 1,  2, 4'h4, 2, 0, 0, 0});
    tbl.push_back('{0, 0, 4'b0101, 0, 0, 1, 8,  3, 4'hF, 2, 0, 0, 0});
    tbl.push_back('{0, 0, 4'b0101, 0, 0, 1, 8,  0, 4'h0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 4'b0101, 0, 0, 1, 1,  0, 4'h0, 0, 0, 0, 0});
    // drip on zone 3, no pesticide
    tbl.push_back('{1, 0, 4'b1000, 1, 0, 0, 1,  1, 4'h0, 3, 0, 0, 1});
    tbl.push_back('{0, 0, 4'b1000, 1, 0, 0, 12, 2, 4'h8, 5, 1, 0, 1});
    tbl.push_back('{0, 0, 4'b1000, 1, 0, 0, 19, 2, 4'h8, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 4'b1000, 1, 0, 0, 1,  0, 4'h0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 4'b1000, 1, 0, 0, 3,  0, 4'h0, 0, 0, 0, 1});
    // nothing dry
    tbl.push_back('{1, 0, 4'b0000, 0, 0, 1, 1,  0, 4'h0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 4'b0000, 0, 0, 1, 1,  0, 4'h0, 0, 0, 0, 0});

    wait_cyc(2);
    chk("reset_state", 32'(dut_out()), 32'h0);
    reset_n = 1'b1;
    wait_cyc(1);

    foreach (tbl[v]) begin
      start = tbl[v].start;
      stop  = tbl[v].stop;
      soil  = tbl[v].soil;
      temp  = tbl[v].temp;
      air   = tbl[v].air;
      pest  = tbl[v].pest;
      for (int i = 0; i < tbl[v].n; i++) begin
        cyc();
        start = 1'b0;
        stop  = 1'b0;
      end
      chk($sformatf("vec%0d", v),
          {state_o, zone_valve_o, remaining_o, mode_o,
           done_o, alert_np_o},
          {tbl[v].st, tbl[v].zv, tbl[v].rem, tbl[v].mode,
           tbl[v].done, tbl[v].alert});
    end

    // abort in zone 1 with pesticide
    soil = 4'b0110; pest = 1'b1; temp = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_cyc(12);
    chk("stop_pre_zone", {state_o, zone_valve_o}, {3'd2, 4'b0010});
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_clean", {state_o, zone_valve_o}, {3'd3, 4'hF});
    wait_cyc(8);
    chk("stop_idle", {state_o, done_o}, {3'd0, 1'b1});
    wait_cyc(4);
    chk("stop_pend_clr", {state_o, zone_valve_o}, {3'd0, 4'h0});

    // start ignored in FILL; start+stop in IRRIGATE aborts
    soil = 4'b0011; pest = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_cyc(2);
    soil = 4'b1111; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_in_fill", {state_o, remaining_o}, {3'd1, 8'd3});
    wait_cyc(9);
    chk("irr_zone0", {state_o, zone_valve_o}, {3'd2, 4'h1});
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("start_stop", {state_o, done_o, zone_valve_o},
        {3'd0, 1'b1, 4'h0});

    // reset mid-run, then rr must restart at zone 0
    soil = 4'b1111; pest = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_cyc(21);
    chk("pre_reset_zone1", zone_valve_o, 4'b0010);
    reset_n = 1'b0;
    cyc();
    chk("mid_reset", 32'(dut_out()), 32'h0);
    reset_n = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_cyc(12);
    chk("rr_after_reset", {state_o, zone_valve_o}, {3'd2, 4'h1});
    wait_cyc(8);
    chk("rr_next", zone_valve_o, 4'b0010);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom % 16) == 0;
      stop    = ($urandom % 50) == 0;
      soil    = 4'($urandom);
      temp    = 1'($urandom);
      air     = 1'($urandom);
      pest    = 1'($urandom);
      reset_n = ($urandom % 500) != 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
